// File: rtl/q_channel_pkg.sv
// Q-Channel shared types: controller/device state encoding
// and synchronizer reset values.
package q_channel_pkg;

  typedef enum logic [2:0] {
    Q_RUN,
    Q_REQUEST,
    Q_STOPPED,
    Q_EXIT,
    Q_DENIED
  } q_state_t;

  localparam logic QACTIVE_RST  = 1'b0;
  localparam logic QACCEPTN_RST = 1'b1;
  localparam logic QDENY_RST    = 1'b0;

endpackage

// File: rtl/q_sync.sv
// Two-flop synchronizer for asynchronous Q-Channel device
// inputs, with a configurable reset value.
module q_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/q_channel_ctrl.sv
// Q-Channel controller: idle detection, quiescence handshake,
// deny handling, request timeout and protocol error flags.
module q_channel_ctrl
  import q_channel_pkg::*;
#(
  parameter int IDLE_THRESH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sleep_en_i,
  input  logic qactive_i,
  input  logic qacceptn_i,
  input  logic qdeny_i,
  output logic qreqn_o,
  output logic stopped_o,
  output logic denied_o,
  output logic timeout_o,
  output logic proto_err_o
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_THRESH - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic active_s, acceptn_s, deny_s;
  logic idle;

  q_state_t   state, state_nx;
  logic [7:0] idle_cnt, idle_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       qreqn_nx, denied_nx;
  logic       timeout_nx, proto_nx;

  q_sync #(.RESET_VAL(QACTIVE_RST)) u_sync_active (
    .clk(clk), .reset(reset), .d(qactive_i), .q(active_s)
  );
  q_sync #(.RESET_VAL(QACCEPTN_RST)) u_sync_acceptn (
    .clk(clk), .reset(reset), .d(qacceptn_i), .q(acceptn_s)
  );
  q_sync #(.RESET_VAL(QDENY_RST)) u_sync_deny (
    .clk(clk), .reset(reset), .d(qdeny_i), .q(deny_s)
  );

  assign idle = sleep_en_i & ~active_s & acceptn_s & ~deny_s;

  always_comb begin
    state_nx   = state;
    idle_nx    = 8'd0;
    wait_nx    = 8'd0;
    qreqn_nx   = qreqn_o;
    denied_nx  = 1'b0;
    timeout_nx = timeout_o;
    proto_nx   = proto_err_o;
    unique case (state)
      Q_RUN: begin
        qreqn_nx = 1'b1;
        if (idle) begin
          if (idle_cnt == IDLE_LAST) begin
            qreqn_nx = 1'b0;
            state_nx = Q_REQUEST;
          end else begin
            idle_nx = idle_cnt + 8'd1;
          end
        end
      end
      Q_REQUEST: begin
        qreqn_nx = 1'b0;
        if (wait_cnt == WAIT_LAST)
          timeout_nx = 1'b1;
        // accept wins over a simultaneous deny
        if (!acceptn_s) begin
          state_nx = Q_STOPPED;
          if (deny_s)
            proto_nx = 1'b1;
        end else if (deny_s) begin
          qreqn_nx  = 1'b1;
          denied_nx = 1'b1;
          state_nx  = Q_DENIED;
        end else begin
          wait_nx = (wait_cnt == 8'hff) ? wait_cnt
                                         : wait_cnt + 8'd1;
        end
      end
      Q_STOPPED: begin
        qreqn_nx = 1'b0;
        if (acceptn_s && !qreqn_o)
          proto_nx = 1'b1;
        if (active_s || !sleep_en_i) begin
          qreqn_nx = 1'b1;
          state_nx = Q_EXIT;
        end
      end
      Q_EXIT: begin
        qreqn_nx = 1'b1;
        if (acceptn_s)
          state_nx = Q_RUN;
      end
      Q_DENIED: begin
        qreqn_nx = 1'b1;
        if (!deny_s)
          state_nx = Q_RUN;
      end
      default: begin
        qreqn_nx = 1'b1;
        state_nx = Q_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= Q_RUN;
      idle_cnt    <= 8'd0;
      wait_cnt    <= 8'd0;
      qreqn_o     <= 1'b1;
      stopped_o   <= 1'b0;
      denied_o    <= 1'b0;
      timeout_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_nx;
      idle_cnt    <= idle_nx;
      wait_cnt    <= wait_nx;
      qreqn_o     <= qreqn_nx;
      stopped_o   <= (state_nx == Q_STOPPED);
      denied_o    <= denied_nx;
      timeout_o   <= timeout_nx;
      proto_err_o <= proto_nx;
    end
  end

endmodule

// File: tb/tb_q_channel_ctrl.sv
// Self-checking bench for q_channel_ctrl: timed expectations are
// queued per scenario and compared as the cycles arrive.
module tb_q_channel_ctrl;
  import q_channel_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sleep_en_i, qactive_i, qacceptn_i, qdeny_i;
  logic qreqn_o, stopped_o, denied_o, timeout_o, proto_err_o;

  typedef struct {
    int         cyc;
    logic [4:0] outs;
    q_state_t   st;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;

  q_channel_ctrl #(.IDLE_THRESH(16), .TIMEOUT(64)) dut (
    .clk(clk),
    .reset(reset),
    .sleep_en_i(sleep_en_i),
    .qactive_i(qactive_i),
    .qacceptn_i(qacceptn_i),
    .qdeny_i(qdeny_i),
    .qreqn_o(qreqn_o),
    .stopped_o(stopped_o),
    .denied_o(denied_o),
    .timeout_o(timeout_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [4:0] outs();
    return {qreqn_o, stopped_o, denied_o, timeout_o, proto_err_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, logic [4:0] o, q_state_t s, string n);
    exp_t x;
    x.cyc = c; x.outs = o; x.st = s; x.name = n;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    sleep_en_i = 1'b1;
    qactive_i = 1'b0;
    qacceptn_i = 1'b1;
    qdeny_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sleep_en_i = 1'b0;
    qactive_i = 1'b1;
    qacceptn_i = 1'b0;
    qdeny_i = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", outs(), 5'b10000);
    end
    checks++;
    if (dut.state !== Q_RUN) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, Q_RUN);
    end
  endtask

  task automatic test_idle_wake();
    int n = 0;
    int k;
    do_reset();
    push(15, 5'b10000, Q_RUN,     "idle_pre_req");
    push(16, 5'b00000, Q_REQUEST, "idle_req");
    push(18, 5'b00000, Q_REQUEST, "acc_wait");
    push(19, 5'b01000, Q_STOPPED, "acc_stop");
    push(24, 5'b01000, Q_STOPPED, "wake_wait");
    push(25, 5'b10000, Q_EXIT,    "wake_exit");
    push(29, 5'b10000, Q_EXIT,    "exit_wait");
    push(30, 5'b10000, Q_RUN,     "exit_run");
    push(40, 5'b10000, Q_RUN,     "active_no_req");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 16) qacceptn_i = 1'b0;
      if (k == 22) qactive_i = 1'b1;
      if (k == 27) qacceptn_i = 1'b1;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_wake: cycle budget expired");
      exp_q.delete();
    end
  endtask

  task automatic test_idle_reset();
    int n = 0;
    int k;
    do_reset();
    push(16, 5'b10000, Q_RUN,     "idlerst_no_req");
    push(27, 5'b10000, Q_RUN,     "idlerst_pre_req");
    push(28, 5'b00000, Q_REQUEST, "idlerst_req");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 9)  qactive_i = 1'b1;
      if (k == 10) qactive_i = 1'b0;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_reset: cycle budget expired");
      exp_q.delete();
    end
  endtask

  task automatic test_deny();
    int n = 0;
    int k;
    do_reset();
    push(18, 5'b00000, Q_REQUEST, "deny_wait");
    push(19, 5'b10100, Q_DENIED,  "deny_pulse");
    push(20, 5'b10000, Q_DENIED,  "deny_pulse_end");
    push(27, 5'b10000, Q_DENIED,  "deny_hold");
    push(28, 5'b10000, Q_RUN,     "deny_run");
    push(43, 5'b10000, Q_RUN,     "deny_idle_pre");
    push(44, 5'b00000, Q_REQUEST, "deny_idle_req");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 16) qdeny_i = 1'b1;
      if (k == 25) qdeny_i = 1'b0;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL deny: cycle budget expired");
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int k;
    do_reset();
    push(79,  5'b00000, Q_REQUEST, "to_pre");
    push(80,  5'b00010, Q_REQUEST, "to_set");
    push(100, 5'b00010, Q_REQUEST, "to_hold");
    push(112, 5'b00010, Q_REQUEST, "to_late_wait");
    push(113, 5'b01010, Q_STOPPED, "to_late_stop");
    push(122, 5'b01010, Q_STOPPED, "stop_release_wait");
    push(123, 5'b01011, Q_STOPPED, "stop_release_err");
    push(126, 5'b01011, Q_STOPPED, "stop_release_hold");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 110) qacceptn_i = 1'b0;
      if (k == 120) qacceptn_i = 1'b1;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: cycle budget expired");
      exp_q.delete();
    end
  endtask

  task automatic test_proto();
    int n = 0;
    int k;
    do_reset();
    push(18, 5'b00000, Q_REQUEST, "pe_wait");
    push(19, 5'b01001, Q_STOPPED, "pe_stop");
    push(22, 5'b01001, Q_STOPPED, "pe_hold");
    push(23, 5'b10001, Q_EXIT,    "pe_sleep_exit");
    push(27, 5'b10001, Q_EXIT,    "pe_exit_wait");
    push(28, 5'b10001, Q_RUN,     "pe_run");
    push(40, 5'b10001, Q_RUN,     "pe_sticky");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 16) begin
        qacceptn_i = 1'b0;
        qdeny_i = 1'b1;
      end
      if (k == 22) sleep_en_i = 1'b0;
      if (k == 25) begin
        qacceptn_i = 1'b1;
        qdeny_i = 1'b0;
      end
      if (k == 30) sleep_en_i = 1'b1;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL proto: cycle budget expired");
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int k;
    do_reset();
    push(19, 5'b01001, Q_STOPPED, "rm_stop");
    push(22, 5'b01001, Q_STOPPED, "rm_pre_reset");
    push(23, 5'b10000, Q_RUN,     "rm_after_reset");
    push(24, 5'b10000, Q_RUN,     "rm_run");
    while (exp_q.size() > 0 && n < 400) begin
      k = cyc - base;
      if (k == 16) begin
        qacceptn_i = 1'b0;
        qdeny_i = 1'b1;
      end
      if (k == 22) reset = 1'b1;
      if (k == 23) reset = 1'b0;
      tick();
      n++;
      if (exp_q[0].cyc == cyc - base) begin
        e = exp_q.pop_front();
        checks++;
        if (outs() !== e.outs || dut.state !== e.st) begin
          errors++;
          $display("FAIL %s: got outs=%b st=%0d want outs=%b st=%0d",
                   e.name, outs(), dut.state, e.outs, e.st);
        end
      end
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: cycle budget expired");
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    sleep_en_i = 1'b0;
    qactive_i = 1'b0;
    qacceptn_i = 1'b1;
    qdeny_i = 1'b0;
    test_reset();
    test_idle_wake();
    test_idle_reset();
    test_deny();
    test_timeout();
    test_proto();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
